// File: rtl/stream_arbiter_rr.sv
// N-input valid/ready arbiter for dcache request streams, with fixed-priority
// or round-robin selection, multi-beat burst locking and a registered output stage.
module stream_arbiter_rr #(
  parameter  int N  = 4,
  parameter  int W  = 64,
  parameter  int RR = 1,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   io_in_valid,
  output logic [N-1:0]   io_in_ready,
  input  logic [N-1:0]   io_in_last,
  input  logic [N*W-1:0] io_in_bits,
  output logic           io_out_valid,
  input  logic           io_out_ready,
  output logic [W-1:0]   io_out_bits,
  output logic           io_out_last,
  output logic [CW-1:0]  io_out_chosen,
  output logic           io_locked
);

  logic          load;
  logic [N-1:0]  grant;
  logic [CW-1:0] grant_idx;
  logic          any_grant;
  logic          found;
  logic [CW:0]   cand_wide;
  logic [CW-1:0] cand;
  logic          win_last;
  logic [W-1:0]  win_bits;

  logic          lock_q;
  logic [CW-1:0] lock_idx_q;
  logic [CW-1:0] ptr_q;

  assign load = io_out_ready | ~io_out_valid;

  // A held lock restricts eligibility to the burst owner; otherwise scan by policy.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand_wide = '0;
    cand      = '0;
    if (lock_q) begin
      if (io_in_valid[lock_idx_q]) begin
        grant[lock_idx_q] = 1'b1;
        grant_idx         = lock_idx_q;
      end
    end else if (RR == 0) begin
      for (int i = 0; i < N; i++) begin
        if (!found && io_in_valid[i]) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = CW'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cand_wide = {1'b0, ptr_q} + (CW+1)'(1) + (CW+1)'(k);
        if (cand_wide >= (CW+1)'(N))
          cand_wide = cand_wide - (CW+1)'(N);
        cand = cand_wide[CW-1:0];
        if (!found && io_in_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign any_grant = |grant;
  assign win_last  = io_in_last[grant_idx];
  assign win_bits  = io_in_bits[grant_idx*W +: W];

  // Reset is folded in so no source sees an accept while state is being cleared.
  assign io_in_ready = (load && !reset) ? grant : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_valid  <= 1'b0;
      io_out_bits   <= '0;
      io_out_last   <= 1'b0;
      io_out_chosen <= '0;
    end else if (load) begin
      io_out_valid <= any_grant;
      if (any_grant) begin
        io_out_bits   <= win_bits;
        io_out_last   <= win_last;
        io_out_chosen <= grant_idx;
      end
    end
  end

  // Lock and pointer both move only on an actual transfer; the pointer
  // advances only when a request finishes, so bursts never rotate priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      ptr_q      <= CW'(N - 1);
    end else if (load && any_grant) begin
      if (win_last) begin
        lock_q <= 1'b0;
        if (RR != 0)
          ptr_q <= grant_idx;
      end else begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant_idx;
      end
    end
  end

  assign io_locked = lock_q;

endmodule

// File: tb/tb_stream_arbiter_rr.sv
// Directed bench for stream_arbiter_rr: a round-robin and a fixed-priority
// instance share stimulus; each scenario checks hand-computed outputs.
module tb_stream_arbiter_rr;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [31:0] in_bits;
  logic        out_ready;

  logic [3:0]  rr_in_ready;
  logic        rr_out_valid;
  logic [7:0]  rr_out_bits;
  logic        rr_out_last;
  logic [1:0]  rr_out_chosen;
  logic        rr_locked;

  logic [3:0]  fp_in_ready;
  logic        fp_out_valid;
  logic [7:0]  fp_out_bits;
  logic        fp_out_last;
  logic [1:0]  fp_out_chosen;
  logic        fp_locked;

  int total = 0;
  int bad   = 0;

  stream_arbiter_rr #(.N(4), .W(8), .RR(1)) u_rr (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(rr_in_ready),
    .io_in_last(in_last), .io_in_bits(in_bits),
    .io_out_valid(rr_out_valid), .io_out_ready(out_ready),
    .io_out_bits(rr_out_bits), .io_out_last(rr_out_last),
    .io_out_chosen(rr_out_chosen), .io_locked(rr_locked)
  );

  stream_arbiter_rr #(.N(4), .W(8), .RR(0)) u_fp (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(fp_in_ready),
    .io_in_last(in_last), .io_in_bits(in_bits),
    .io_out_valid(fp_out_valid), .io_out_ready(out_ready),
    .io_out_bits(fp_out_bits), .io_out_last(fp_out_last),
    .io_out_chosen(fp_out_chosen), .io_locked(fp_locked)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l,
                               input logic [31:0] b, input logic r);
    in_valid  = v;
    in_last   = l;
    in_bits   = b;
    out_ready = r;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] rr_seq [6];
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset held two cycles with every channel requesting.
    reset = 1'b1;
    applyStimulus(4'hF, 4'hF, 32'hC3C2C1C0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      step();
      checkOutput("rst_valid", {31'd0, rr_out_valid}, 32'd0);
      checkOutput("rst_locked", {31'd0, rr_locked}, 32'd0);
      checkOutput("rst_ready", {28'd0, rr_in_ready}, 32'h0);
      checkOutput("rst_ready_fp", {28'd0, fp_in_ready}, 32'h0);
    end
    checkOutput("rst_bits", {24'd0, rr_out_bits}, 32'h0);
    checkOutput("rst_chosen", {30'd0, rr_out_chosen}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("first_grant", {28'd0, rr_in_ready}, 32'h1);

    // Round robin over four always-valid single-beat channels.
    for (int c = 0; c < 6; c++) begin
      step();
      checkOutput("rr_valid", {31'd0, rr_out_valid}, 32'd1);
      checkOutput("rr_chosen", {30'd0, rr_out_chosen}, {30'd0, rr_seq[c]});
      checkOutput("rr_bits", {24'd0, rr_out_bits}, 32'hC0 + {30'd0, rr_seq[c]});
    end
    checkOutput("rr_last", {31'd0, rr_out_last}, 32'd1);

    // Fixed priority: channel 1 always beats channel 3.
    applyStimulus(4'h0, 4'hF, 32'h0, 1'b1);
    pulseReset();
    applyStimulus(4'b1010, 4'hF, 32'h33001100, 1'b1);
    #1;
    checkOutput("fp_ready0", {28'd0, fp_in_ready}, 32'h2);
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("fp_valid", {31'd0, fp_out_valid}, 32'd1);
      checkOutput("fp_bits", {24'd0, fp_out_bits}, 32'h11);
      checkOutput("fp_chosen", {30'd0, fp_out_chosen}, 32'd1);
      checkOutput("fp_ready", {28'd0, fp_in_ready}, 32'h2);
    end

    // Burst lock: channel 2 sends three beats while channel 0 waits.
    applyStimulus(4'h0, 4'hF, 32'h0, 1'b1);
    pulseReset();
    applyStimulus(4'b0100, 4'b0000, 32'h00210005, 1'b1);
    #1;
    checkOutput("bl_ready1", {28'd0, rr_in_ready}, 32'h4);
    step();
    checkOutput("bl_chosen1", {30'd0, rr_out_chosen}, 32'd2);
    checkOutput("bl_bits1", {24'd0, rr_out_bits}, 32'h21);
    checkOutput("bl_locked1", {31'd0, rr_locked}, 32'd1);
    applyStimulus(4'b0101, 4'b0001, 32'h00220005, 1'b1);
    #1;
    checkOutput("bl_ready2", {28'd0, rr_in_ready}, 32'h4);
    step();
    checkOutput("bl_bits2", {24'd0, rr_out_bits}, 32'h22);
    checkOutput("bl_locked2", {31'd0, rr_locked}, 32'd1);
    applyStimulus(4'b0101, 4'b0101, 32'h00230005, 1'b1);
    #1;
    checkOutput("bl_ready3", {28'd0, rr_in_ready}, 32'h4);
    step();
    checkOutput("bl_bits3", {24'd0, rr_out_bits}, 32'h23);
    checkOutput("bl_chosen3", {30'd0, rr_out_chosen}, 32'd2);
    checkOutput("bl_unlock", {31'd0, rr_locked}, 32'd0);
    applyStimulus(4'b0001, 4'b0101, 32'h00230005, 1'b1);
    #1;
    checkOutput("bl_ready_ch0", {28'd0, rr_in_ready}, 32'h1);
    step();
    checkOutput("bl_ch0_chosen", {30'd0, rr_out_chosen}, 32'd0);
    checkOutput("bl_ch0_bits", {24'd0, rr_out_bits}, 32'h05);

    // Burst owner drops valid mid-burst: output bubbles, channel 0 stalls.
    applyStimulus(4'b0101, 4'b0001, 32'h00310005, 1'b1);
    #1;
    checkOutput("gap_ready1", {28'd0, rr_in_ready}, 32'h4);
    step();
    checkOutput("gap_locked", {31'd0, rr_locked}, 32'd1);
    applyStimulus(4'b0001, 4'b0001, 32'h00310005, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      checkOutput("gap_stall", {28'd0, rr_in_ready}, 32'h0);
      step();
      checkOutput("gap_valid", {31'd0, rr_out_valid}, 32'd0);
      checkOutput("gap_still_locked", {31'd0, rr_locked}, 32'd1);
    end
    applyStimulus(4'b0101, 4'b0101, 32'h00320005, 1'b1);
    step();
    checkOutput("gap_end_bits", {24'd0, rr_out_bits}, 32'h32);
    checkOutput("gap_end_unlock", {31'd0, rr_locked}, 32'd0);
    applyStimulus(4'b0001, 4'b0001, 32'h00000005, 1'b1);
    step();
    checkOutput("gap_ch0", {30'd0, rr_out_chosen}, 32'd0);

    // Backpressure holds the 0xAA beat for five cycles.
    applyStimulus(4'h0, 4'hF, 32'h0, 1'b1);
    pulseReset();
    applyStimulus(4'b0001, 4'hF, 32'h000000AA, 1'b1);
    step();
    checkOutput("bp_first", {24'd0, rr_out_bits}, 32'hAA);
    applyStimulus(4'b0010, 4'hF, 32'h0000BB00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("bp_ready", {28'd0, rr_in_ready}, 32'h0);
      step();
      checkOutput("bp_valid", {31'd0, rr_out_valid}, 32'd1);
      checkOutput("bp_bits", {24'd0, rr_out_bits}, 32'hAA);
      checkOutput("bp_chosen", {30'd0, rr_out_chosen}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {28'd0, rr_in_ready}, 32'h2);
    step();
    checkOutput("bp_next_bits", {24'd0, rr_out_bits}, 32'hBB);
    checkOutput("bp_next_chosen", {30'd0, rr_out_chosen}, 32'd1);

    // Reset after the first beat of a channel-1 burst.
    applyStimulus(4'h0, 4'hF, 32'h0, 1'b1);
    pulseReset();
    applyStimulus(4'b0010, 4'b0000, 32'h00004100, 1'b1);
    step();
    checkOutput("mr_locked", {31'd0, rr_locked}, 32'd1);
    checkOutput("mr_chosen", {30'd0, rr_out_chosen}, 32'd1);
    applyStimulus(4'b0011, 4'b0001, 32'h00004250, 1'b1);
    reset = 1'b1;
    step();
    checkOutput("mr_rst_locked", {31'd0, rr_locked}, 32'd0);
    checkOutput("mr_rst_valid", {31'd0, rr_out_valid}, 32'd0);
    checkOutput("mr_rst_ready", {28'd0, rr_in_ready}, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("mr_ready_ch0", {28'd0, rr_in_ready}, 32'h1);
    step();
    checkOutput("mr_ch0_chosen", {30'd0, rr_out_chosen}, 32'd0);
    checkOutput("mr_ch0_bits", {24'd0, rr_out_bits}, 32'h50);
    checkOutput("mr_ch0_unlocked", {31'd0, rr_locked}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
